// File: rtl/alib_topk_frequency_ranker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alib_topk_frequency_ranker
//
// Counts how often each symbol appears on N parallel input lanes. On request,
// it ranks every symbol by frequency. Rank 0 is the most frequent symbol.
// Ties are broken in favour of the lower symbol value, so the ranks always
// form a permutation of 0..D-1, where D = 2^SYMBOL_BITS.
//
// Optional build macro:
//   ALIB_RFT_SATURATE_EN  defined   -> counters saturate at 2^COUNTER_BITS-1
//                         undefined -> counters wrap modulo 2^COUNTER_BITS
//
// Ports:
//   i_clk              clock; all state changes on the rising edge
//   i_rst              asynchronous, active-low reset
//   i_char             N concatenated lane symbols; lane k is at
//                      [k*SYMBOL_BITS +: SYMBOL_BITS]
//   i_valid            per-lane valid
//   i_clear            pulse: zero all counters (runs a D-cycle sweep)
//   i_start_rank_calc  pulse: rank all symbols (takes D+1 cycles)
//   i_query_char       symbol to look up
//   o_ready            high in COUNT or DONE, when symbols are accepted
//   o_rank_done        high in DONE, while the rank table is current
//   o_query_rank       registered rank of i_query_char
//   o_query_count      registered count of i_query_char
// ---------------------------------------------------------------------------
module alib_topk_frequency_ranker #(
    parameter int SYMBOL_BITS            = 8,
    parameter int COUNTER_BITS           = 16,
    parameter int NUMBER_PARALLEL_INPUTS = 8
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic [SYMBOL_BITS*NUMBER_PARALLEL_INPUTS-1:0] i_char,
    input  logic [NUMBER_PARALLEL_INPUTS-1:0]             i_valid,
    input  logic                                          i_clear,
    input  logic                                          i_start_rank_calc,
    input  logic [SYMBOL_BITS-1:0]                        i_query_char,
    output logic                                          o_ready,
    output logic                                          o_rank_done,
    output logic [SYMBOL_BITS-1:0]                        o_query_rank,
    output logic [COUNTER_BITS-1:0]                       o_query_count
);

    localparam int DEPTH = 1 << SYMBOL_BITS;
    localparam int N     = NUMBER_PARALLEL_INPUTS;
    localparam int INC_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_COUNT,
        ST_RANK,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SYMBOL_BITS-1:0]  idx_q, idx_d;

    // The counters are read in parallel during ranking, so they live in
    // flops rather than block RAM.
    logic [COUNTER_BITS-1:0] count_q      [DEPTH];
    logic [COUNTER_BITS-1:0] count_next_w [DEPTH];
    logic [SYMBOL_BITS-1:0]  rank_q       [DEPTH];
    logic                    beats_w      [DEPTH];
    logic [COUNTER_BITS-1:0] rank_cnt_w;

    logic                    accept;
    logic                    rank_clear;
    logic                    rank_step;

    logic [SYMBOL_BITS-1:0]  query_rank_q;
    logic [COUNTER_BITS-1:0] query_count_q;

    // This is the count of the symbol currently being compared against all others.
    assign rank_cnt_w = count_q[idx_q];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sym
            logic [INC_W-1:0]      hits;
            logic [COUNTER_BITS:0] sum;

            // Count how many lanes carry this symbol in this cycle
            // (multiplicity 0..N).
            always_comb begin
                hits = '0;
                for (int k = 0; k < N; k++) begin
                    if (i_valid[k] && (i_char[k*SYMBOL_BITS +: SYMBOL_BITS] == SYMBOL_BITS'(gi))) begin
                        hits = hits + INC_W'(1);
                    end
                end
            end

            assign sum = {1'b0, count_q[gi]} + (COUNTER_BITS+1)'(hits);

`ifdef ALIB_RFT_SATURATE_EN
            assign count_next_w[gi] = sum[COUNTER_BITS] ? {COUNTER_BITS{1'b1}} : sum[COUNTER_BITS-1:0];
`else
            assign count_next_w[gi] = sum[COUNTER_BITS-1:0];
`endif

            // Symbol idx_q beats symbol gi if it has a larger count.
            // If the counts are equal, the lower symbol value wins.
            assign beats_w[gi] = (rank_cnt_w > count_q[gi]) ||
                                 ((rank_cnt_w == count_q[gi]) && (idx_q < SYMBOL_BITS'(gi)));
        end
    endgenerate

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic. Clear has priority over everything, including start.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        accept     = 1'b0;
        rank_clear = 1'b0;
        rank_step  = 1'b0;
        if (i_clear) begin
            state_d = ST_CLEAR;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    idx_d = idx_q + SYMBOL_BITS'(1);
                    if (idx_q == {SYMBOL_BITS{1'b1}}) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    accept = 1'b1;
                    if (i_start_rank_calc) begin
                        state_d    = ST_RANK;
                        idx_d      = '0;
                        rank_clear = 1'b1;
                    end
                end
                ST_RANK: begin
                    rank_step = 1'b1;
                    idx_d     = idx_q + SYMBOL_BITS'(1);
                    if (idx_q == {SYMBOL_BITS{1'b1}}) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    accept = 1'b1;
                    if (i_start_rank_calc) begin
                        state_d    = ST_RANK;
                        idx_d      = '0;
                        rank_clear = 1'b1;
                    end else if (|i_valid) begin
                        // New data makes the rank table stale.
                        state_d = ST_COUNT;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Counters are deliberately not reset.
    // The CLEAR sweep after reset release zeroes them one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int s = 0; s < DEPTH; s++) begin
                count_q[s] <= count_next_w[s];
            end
        end
        if (state_q == ST_CLEAR) begin
            count_q[idx_q] <= '0;
        end
    end

    // Rank table
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                rank_q[s] <= '0;
            end
        end else if (rank_clear) begin
            for (int s = 0; s < DEPTH; s++) begin
                rank_q[s] <= '0;
            end
        end else if (rank_step) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (beats_w[s]) begin
                    rank_q[s] <= rank_q[s] + SYMBOL_BITS'(1);
                end
            end
        end
    end

    // Registered query port with one-cycle latency
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            query_rank_q  <= '0;
            query_count_q <= '0;
        end else begin
            query_rank_q  <= rank_q[i_query_char];
            query_count_q <= count_q[i_query_char];
        end
    end

    assign o_ready       = (state_q == ST_COUNT) || (state_q == ST_DONE);
    assign o_rank_done   = (state_q == ST_DONE);
    assign o_query_rank  = query_rank_q;
    assign o_query_count = query_count_q;

endmodule

// File: tb/tb_alib_topk_frequency_ranker.sv
`timescale 1ns/1ps
module tb_alib_topk_frequency_ranker;

    localparam int SB   = 8;
    localparam int N    = 8;
    localparam int CB   = 16;
    localparam int CB_S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;

    // Main instance (default parameters)
    logic [SB*N-1:0] chr;
    logic [N-1:0]    vld;
    logic            clr;
    logic            start;
    logic [SB-1:0]   qchar;
    logic            ready;
    logic            done;
    logic [SB-1:0]   qrank;
    logic [CB-1:0]   qcount;

    // Narrow-counter instance for wrap/saturate checks
    logic [SB*N-1:0] s_chr;
    logic [N-1:0]    s_vld;
    logic            s_clr;
    logic            s_start;
    logic [SB-1:0]   s_qchar;
    logic            s_ready;
    logic            s_done;
    logic [SB-1:0]   s_qrank;
    logic [CB_S-1:0] s_qcount;

    int total = 0;
    int bad   = 0;

    alib_topk_frequency_ranker #(
        .SYMBOL_BITS(SB), .COUNTER_BITS(CB), .NUMBER_PARALLEL_INPUTS(N)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_char(chr), .i_valid(vld),
        .i_clear(clr), .i_start_rank_calc(start), .i_query_char(qchar),
        .o_ready(ready), .o_rank_done(done),
        .o_query_rank(qrank), .o_query_count(qcount)
    );

    alib_topk_frequency_ranker #(
        .SYMBOL_BITS(SB), .COUNTER_BITS(CB_S), .NUMBER_PARALLEL_INPUTS(N)
    ) dut_sat (
        .i_clk(clk), .i_rst(rst_n), .i_char(s_chr), .i_valid(s_vld),
        .i_clear(s_clr), .i_start_rank_calc(s_start), .i_query_char(s_qchar),
        .o_ready(s_ready), .o_rank_done(s_done),
        .o_query_rank(s_qrank), .o_query_count(s_qcount)
    );

    // Advance n rising edges, then settle 1ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a query symbol; after return, qrank/qcount hold its values.
    task automatic query(input logic [SB-1:0] sym);
        qchar = sym;
        step(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        chr = '0; vld = '0; clr = 1'b0; start = 1'b0; qchar = '0;
        s_chr = '0; s_vld = '0; s_clr = 1'b0; s_start = 1'b0; s_qchar = '0;
        step(3);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++; if (qrank !== 8'd0) begin bad++; $display("FAIL reset_qrank: got %0d expected 0", qrank); end
        total++; if (qcount !== 16'd0) begin bad++; $display("FAIL reset_qcount: got %0d expected 0", qcount); end
        total++; if (s_qcount !== 4'd0) begin bad++; $display("FAIL reset_sat_qcount: got %0d expected 0", s_qcount); end
        rst_n = 1'b1;
        step(255);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL sweep_ready_255: got %b expected 0", ready); end
        step(1);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL sweep_ready_256: got %b expected 1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL sweep_done: got %b expected 0", done); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL sweep_sat_ready: got %b expected 1", s_ready); end
        for (int s = 0; s < 256; s++) begin
            query(8'(s));
            total++;
            if (qcount !== 16'd0) begin bad++; $display("FAIL post_reset_count[%0d]: got %0d expected 0", s, qcount); end
        end
        $display("reset sweep checked");
    endtask

    task automatic test_rank_basic();
        logic [7:0] syms [7];
        logic [7:0] exp_r [7];
        syms  = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h00, 8'h01, 8'hFF};
        exp_r = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd255};
        chr = {8'h41, 8'h42, 8'h43, 8'h44, 32'h0};
        vld = 8'hF0;
        step(1);
        vld = '0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(255);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rank_latency_256: got %b expected 0", done); end
        step(1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rank_latency_257: got %b expected 1", done); end
        for (int i = 0; i < 7; i++) begin
            query(syms[i]);
            total++;
            if (qrank !== exp_r[i]) begin bad++; $display("FAIL basic_rank[%h]: got %0d expected %0d", syms[i], qrank, exp_r[i]); end
        end
        query(8'h41);
        total++; if (qcount !== 16'd1) begin bad++; $display("FAIL basic_count_41: got %0d expected 1", qcount); end
        $display("basic rank checked");
    endtask

    task automatic test_multiplicity();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL clr_done: got %b expected 0", done); end
        step(255);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL clr_ready_low: got %b expected 0", ready); end
        step(1);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL clr_ready_high: got %b expected 1", ready); end
        chr = {8{8'h4D}};
        vld = 8'hFF;
        step(3);
        chr = {56'h0, 8'h41};
        vld = 8'h01;
        step(1);
        vld = '0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(256);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mult_done: got %b expected 1", done); end
        query(8'h4D);
        total++; if (qcount !== 16'd24) begin bad++; $display("FAIL mult_count_4d: got %0d expected 24", qcount); end
        total++; if (qrank !== 8'd0) begin bad++; $display("FAIL mult_rank_4d: got %0d expected 0", qrank); end
        query(8'h41);
        total++; if (qrank !== 8'd1) begin bad++; $display("FAIL mult_rank_41: got %0d expected 1", qrank); end
        query(8'h00);
        total++; if (qrank !== 8'd2) begin bad++; $display("FAIL mult_rank_00: got %0d expected 2", qrank); end
        $display("multiplicity checked");
    endtask

    task automatic test_done_update();
        chr = {56'h0, 8'h47};
        vld = 8'h01;
        step(1);
        vld = '0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_drop: got %b expected 0", done); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL done_ready: got %b expected 1", ready); end
        query(8'h47);
        total++; if (qcount !== 16'd1) begin bad++; $display("FAIL done_count_47: got %0d expected 1", qcount); end
        start = 1'b1;
        step(1);
        start = 1'b0;
        // These lanes, and a second start pulse, arrive during RANK and must be ignored.
        chr = {8{8'h4D}};
        vld = 8'hFF;
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        vld = '0;
        step(250);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rank2_256: got %b expected 0", done); end
        step(1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rank2_257: got %b expected 1", done); end
        query(8'h4D);
        total++; if (qcount !== 16'd24) begin bad++; $display("FAIL rank_drop_4d: got %0d expected 24", qcount); end
        query(8'h47);
        total++; if (qrank !== 8'd2) begin bad++; $display("FAIL rank2_47: got %0d expected 2", qrank); end
        query(8'h41);
        total++; if (qrank !== 8'd1) begin bad++; $display("FAIL rank2_41: got %0d expected 1", qrank); end
        $display("done update checked");
    endtask

    task automatic test_clear_abort();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(100);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b expected 0", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b expected 0", done); end
        step(255);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready_255: got %b expected 0", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done_255: got %b expected 0", done); end
        step(1);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready_256: got %b expected 1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done_256: got %b expected 0", done); end
        for (int s = 0; s < 256; s++) begin
            query(8'(s));
            total++;
            if (qcount !== 16'd0) begin bad++; $display("FAIL abort_count[%0d]: got %0d expected 0", s, qcount); end
        end
        $display("clear abort checked");
    endtask

    task automatic test_clear_priority();
        chr = {56'h0, 8'h41};
        vld = 8'h01;
        step(1);
        vld = '0;
        clr = 1'b1;
        start = 1'b1;
        step(1);
        clr = 1'b0;
        start = 1'b0;
        step(255);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL prio_ready_255: got %b expected 0", ready); end
        step(1);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL prio_ready_256: got %b expected 1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL prio_done: got %b expected 0", done); end
        query(8'h41);
        total++; if (qcount !== 16'd0) begin bad++; $display("FAIL prio_count_41: got %0d expected 0", qcount); end
        $display("clear priority checked");
    endtask

    task automatic test_saturate();
        logic [CB_S-1:0] exp20;
        logic [CB_S-1:0] exp16;
`ifdef ALIB_RFT_SATURATE_EN
        exp20 = 4'd15;
        exp16 = 4'd15;
`else
        exp20 = 4'd4;
        exp16 = 4'd0;
`endif
        s_chr = {56'h0, 8'h10};
        s_vld = 8'h01;
        step(20);
        s_chr = {8{8'h20}};
        s_vld = 8'hFF;
        step(1);
        s_vld = '0;
        s_qchar = 8'h20;
        step(1);
        total++; if (s_qcount !== 4'd8) begin bad++; $display("FAIL sat_count_20_once: got %0d expected 8", s_qcount); end
        s_vld = 8'hFF;
        step(1);
        s_vld = '0;
        s_qchar = 8'h10;
        step(1);
        total++; if (s_qcount !== exp20) begin bad++; $display("FAIL sat_count_10: got %0d expected %0d", s_qcount, exp20); end
        s_qchar = 8'h20;
        step(1);
        total++; if (s_qcount !== exp16) begin bad++; $display("FAIL sat_count_20_twice: got %0d expected %0d", s_qcount, exp16); end
        $display("counter limit checked");
    endtask

    initial begin
        test_reset();
        test_rank_basic();
        test_multiplicity();
        test_done_update();
        test_clear_abort();
        test_clear_priority();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
